rr_bus_arbiter8: RTL
====================

RR_BUS_ARBITER8 -- requirements
Module: rr_bus_arbiter8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. All other logic SHALL be on the rising edge of clock.
REQ-002 The block SHALL have the following ports:
- clock, input, 1 bit: rising-edge clock.
- reset, input, 1 bit: asynchronous, active-low reset. 0 = in reset.
- req, input, 8 bits: request from requester i on bit i.
- data_in, input, 256 bits: requester i operand on bits [32i+31:32i].
- out_ready, input, 1 bit: sink accepts out_data this cycle.
- grant, output, 8 bits: one-hot registered grant, or 0 when idle.
- grant_id, output, 3 bits: binary index of the current grant.
- out_valid, output, 1 bit: out_data holds a transfer that has not been accepted.
- out_data, output, 32 bits: captured operand of the granted requester.
REQ-003 There SHALL be no parameters; the width is fixed at 32 and the requester count at 8.

Function
REQ-004 The FSM SHALL have two states: IDLE and GRANT. It SHALL also hold a 3-bit round-robin pointer, ptr.
REQ-005 Winner selection SHALL pick the first set req bit found in circular order ptr, ptr+1, ..., ptr+7 (mod 8).
REQ-006 In IDLE with req != 0, the next clock edge SHALL take all of these actions:
- Enter GRANT.
- Set grant to the one-hot code of the winner and grant_id to its index.
- Set out_valid to 1.
- Load out_data from the winner's data_in lane through an internal 32-bit 8:1 mux.
Latency from req to out_valid SHALL be 1 cycle.
REQ-007 In IDLE with req == 0, all outputs SHALL hold their idle values: grant 0, out_valid 0, and out_data and grant_id unchanged.
REQ-008 In GRANT with out_ready == 0, grant, grant_id and out_data SHALL stay stable. Changes on data_in or req SHALL NOT affect them.
REQ-009 A transfer SHALL complete on any edge where out_valid && out_ready. On completion, ptr SHALL load grant_id+1 mod 8, so 7 wraps to 0.
REQ-010 On completion with req != 0, the FSM SHALL stay in GRANT. At that same edge it SHALL select and load a new winner, searching from grant_id+1. This gives back-to-back transfers with no idle cycle.
REQ-011 On completion with req == 0, the FSM SHALL go to IDLE with grant = 0 and out_valid = 0.
REQ-012 If the granted requester deasserts req before acceptance, the transfer SHALL still complete with the captured data. Dropping req SHALL NOT cancel a transfer.
REQ-013 A sole active requester SHALL win on every back-to-back cycle. Round-robin order SHALL only skip requesters whose req bit is clear.
REQ-014 grant SHALL always be one-hot or zero, and SHALL be nonzero if and only if out_valid == 1.
REQ-015 ptr SHALL update only on completion, never on stall cycles.

Reset
REQ-016 While reset == 0 the block SHALL asynchronously force all of the following:
- state = IDLE
- ptr = 0
- grant = 8'h00
- grant_id = 3'd0
- out_valid = 0
- out_data = 32'h0
REQ-017 Reset asserted mid-transfer SHALL discard the pending transfer. No completion SHALL be signalled.
REQ-018 After reset deasserts, the first arbitration SHALL be able to occur on the first rising edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios, with lane i of data_in set to 32'h1000_000i unless stated otherwise:
- Idle after reset: reset released, req = 8'h00 for 10 cycles. Expect out_valid = 0, grant = 8'h00 and out_data = 0 throughout.
- Round-robin between two requesters: req = 8'h05, out_ready held at 1. Expect grant sequence 8'h01, 8'h04, 8'h01, 8'h04 on consecutive cycles, with out_data 32'h1000_0000, 32'h1000_0002, and so on alternating.
- Backpressure: req = 8'h10, out_ready = 0 for 5 cycles, and lane 4 changed to 32'hDEAD_BEEF on cycle 2. Expect grant = 8'h10 and out_data = 32'h1000_0004 held stable. Then set out_ready = 1 with req = 0; the next cycle expects out_valid = 0 and grant = 0.
- Pointer wrap: req = 8'h81, starting with ptr = 7 after a grant to requester 6. Expect grant 8'h80, then grant 8'h01 (pointer wraps 7 to 0).
- Reset mid-transfer: reset driven to 0 while out_valid = 1 and out_ready = 0. Expect immediately, before the next edge, out_valid = 0 and grant = 0. After release with req = 8'h40, expect grant_id = 6 on the first edge.
- Single persistent requester: req = 8'h08 with out_ready = 1. Expect grant = 8'h08 and out_data = 32'h1000_0003 on every cycle, with out_valid continuously 1.

Source files
------------

// File: rtl/rr_bus_arbiter8.sv
// rr_bus_arbiter8
// Eight-way round-robin arbiter that captures the winning requester's 32-bit
// operand into a single output register and holds it until the sink accepts it.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset (0 = in reset)
//   req        request from requester i on bit i
//   data_in    requester i operand on bits [32i+31:32i]
//   out_ready  sink accepts out_data this cycle
//   grant      one-hot registered grant, zero when idle
//   grant_id   binary index of the current grant
//   out_valid  out_data holds a transfer not yet accepted
//   out_data   captured operand of the granted requester
module rr_bus_arbiter8 (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   req,
    input  logic [255:0] data_in,
    input  logic         out_ready,
    output logic [7:0]   grant,
    output logic [2:0]   grant_id,
    output logic         out_valid,
    output logic [31:0]  out_data
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [2:0]  ptr;
    logic [2:0]  searchBase;
    logic [2:0]  probeIdx;
    logic [2:0]  winnerId;
    logic        winnerFound;
    logic [31:0] winnerData;
    logic        complete;
    logic        loadWinner;
    logic        goIdle;

    // A transfer finishes whenever the held data is accepted by the sink.
    assign complete = out_valid && out_ready;

    // While a grant is live, ptr still reflects the previous completion, so the
    // back-to-back search has to start just past the grant being retired.  In
    // IDLE the pointer already holds that value.
    always_comb begin
        searchBase = ptr;
        if (state == GRANT) begin
            searchBase = grant_id + 3'd1;
        end
    end

    // Circular priority search starting at searchBase.  Walking from the far
    // end back toward offset 0 lets the closest set request overwrite any
    // farther one, so the last assignment is the round-robin winner.
    always_comb begin
        winnerFound = 1'b0;
        winnerId    = searchBase;
        probeIdx    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            probeIdx = searchBase + 3'(k);
            if (req[probeIdx]) begin
                winnerFound = 1'b1;
                winnerId    = probeIdx;
            end
        end
    end

    // Operand selection: an 8:1 mux of 32-bit lanes steered by the winner.
    always_comb begin
        winnerData = 32'h0;
        case (winnerId)
            3'd0: winnerData = data_in[31:0];
            3'd1: winnerData = data_in[63:32];
            3'd2: winnerData = data_in[95:64];
            3'd3: winnerData = data_in[127:96];
            3'd4: winnerData = data_in[159:128];
            3'd5: winnerData = data_in[191:160];
            3'd6: winnerData = data_in[223:192];
            3'd7: winnerData = data_in[255:224];
            default: winnerData = 32'h0;
        endcase
    end

    // Next-state logic.  A new winner is loaded either from IDLE or at the
    // same edge that retires the current transfer, which gives back-to-back
    // grants without a bubble.  Without acceptance nothing moves, so the held
    // grant and data ignore any activity on req or data_in.
    always_comb begin
        nextState  = state;
        loadWinner = 1'b0;
        goIdle     = 1'b0;
        case (state)
            IDLE: begin
                if (winnerFound) begin
                    nextState  = GRANT;
                    loadWinner = 1'b1;
                end
            end
            GRANT: begin
                if (complete) begin
                    if (winnerFound) begin
                        loadWinner = 1'b1;
                    end else begin
                        nextState = IDLE;
                        goIdle    = 1'b1;
                    end
                end
            end
            default: begin
                nextState = IDLE;
                goIdle    = 1'b1;
            end
        endcase
    end

    // State, pointer and output registers.  The pointer advances only when a
    // transfer is accepted, never on stall cycles.  Going idle clears grant
    // and out_valid but leaves grant_id and out_data as they were.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            grant     <= 8'h00;
            grant_id  <= 3'd0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else begin
            state <= nextState;
            if (state == GRANT && complete) begin
                ptr <= grant_id + 3'd1;
            end
            if (loadWinner) begin
                grant     <= 8'h01 << winnerId;
                grant_id  <= winnerId;
                out_valid <= 1'b1;
                out_data  <= winnerData;
            end else if (goIdle) begin
                grant     <= 8'h00;
                out_valid <= 1'b0;
            end
        end
    end

endmodule
